// File: rtl/alu_control.sv
// alu_control: registered ALU operation decoder for the RV32 datapath
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   instruccion  instruction word (only bit 30 and bits 14:12 are decoded)
//   ALU_OP       operation class from the main decoder
//   in_valid     instruccion/ALU_OP valid this cycle
//   alu_inst     registered op select: 00 ADD, 01 SUB, 10 AND, 11 OR
//   out_valid    alu_inst/illegal reflect an input accepted on the previous edge
//   illegal      registered flag for unsupported ALU_OP/funct3 combinations
module alu_control #(
    parameter int width_instruction = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [width_instruction-1:0] instruccion,
    input  logic [1:0]                   ALU_OP,
    input  logic                         in_valid,
    output logic [1:0]                   alu_inst,
    output logic                         out_valid,
    output logic                         illegal
);
    logic [2:0] funct3;
    logic       f7b5;
    logic [1:0] dec_inst;
    logic       dec_ill;
    logic       unused_bits;
    assign funct3 = instruccion[14:12];
    assign f7b5   = instruccion[30];
    assign unused_bits = &{1'b0, instruccion};
    // R-type only supports funct3 000 (ADD/SUB), 110 (OR) and 111 (AND)
    assign dec_ill  = ALU_OP == 2'b11 || (ALU_OP == 2'b10 && funct3 != 3'b000 && funct3[2:1] != 2'b11);
    assign dec_inst = ALU_OP == 2'b01 ? 2'b01 :
                      ALU_OP != 2'b10 ? 2'b00 :
                      funct3 == 3'b000 ? {1'b0, f7b5} :
                      funct3 == 3'b111 ? 2'b10 :
                      funct3 == 3'b110 ? 2'b11 : 2'b00;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_inst  <= 2'b00;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_inst <= dec_inst;
                illegal  <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: random and directed checks of alu_control against a reference model
module tb_alu_control;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruccion;
    logic [1:0]  ALU_OP;
    logic        in_valid;
    logic [1:0]  alu_inst;
    logic        out_valid;
    logic        illegal;
    int checks = 0;
    int errors = 0;
    logic [1:0] m_inst = 2'b00;
    logic       m_ill = 1'b0;
    logic       m_valid = 1'b0;

    alu_control #(.width_instruction(32)) dut (
        .clk(clk), .rst(rst), .instruccion(instruccion), .ALU_OP(ALU_OP),
        .in_valid(in_valid), .alu_inst(alu_inst), .out_valid(out_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // returns {illegal, op}
    function automatic logic [2:0] ref_dec(input logic [1:0] op, input logic [31:0] inst);
        logic [2:0] f;
        f = inst[14:12];
        if (op == 2'd0) return 3'b000;
        if (op == 2'd1) return 3'b001;
        if (op == 2'd3) return 3'b100;
        if (f == 3'd0) return inst[30] ? 3'b001 : 3'b000;
        if (f == 3'd7) return 3'b010;
        if (f == 3'd6) return 3'b011;
        return 3'b100;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inst = 2'b00; m_ill = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) {m_ill, m_inst} = ref_dec(ALU_OP, instruccion);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid/ill/inst=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("model_cmp", {out_valid, illegal, alu_inst}, {m_valid, m_ill, m_inst});

    task automatic apply(input logic [1:0] op, input logic [31:0] inst, input logic v);
        ALU_OP = op; instruccion = inst; in_valid = v;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; ALU_OP = 2'b00; instruccion = '0; in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("reset_hold", {out_valid, illegal, alu_inst}, 4'b0000);
            ALU_OP = 2'($urandom); instruccion = $urandom; in_valid = 1'b1;
        end
        rst = 1'b0;
        apply(2'b01, 32'h0, 1'b1); chk("first_after_reset", {out_valid, illegal, alu_inst}, 4'b1001);
        apply(2'b00, 32'h0, 1'b1); chk("class_add", {out_valid, illegal, alu_inst}, 4'b1000);
        apply(2'b01, 32'h0, 1'b1); chk("class_sub", {out_valid, illegal, alu_inst}, 4'b1001);
        apply(2'b10, 32'h00000000, 1'b1); chk("r_add", {out_valid, illegal, alu_inst}, 4'b1000);
        apply(2'b10, 32'h40000000, 1'b1); chk("r_sub", {out_valid, illegal, alu_inst}, 4'b1001);
        apply(2'b10, 32'h00007000, 1'b1); chk("r_and", {out_valid, illegal, alu_inst}, 4'b1010);
        apply(2'b10, 32'h00006000, 1'b1); chk("r_or", {out_valid, illegal, alu_inst}, 4'b1011);
        apply(2'b10, 32'h40007000, 1'b1); chk("f7_and", {out_valid, illegal, alu_inst}, 4'b1010);
        apply(2'b10, 32'h40006000, 1'b1); chk("f7_or", {out_valid, illegal, alu_inst}, 4'b1011);
        apply(2'b10, 32'h00001000, 1'b1); chk("ill_f3", {out_valid, illegal, alu_inst}, 4'b1100);
        apply(2'b01, 32'h0, 1'b1); chk("ill_clear", {out_valid, illegal, alu_inst}, 4'b1001);
        apply(2'b11, 32'h0, 1'b1); chk("ill_op", {out_valid, illegal, alu_inst}, 4'b1100);
        for (int f = 1; f < 6; f++) begin
            apply(2'b10, 32'(f) << 12, 1'b1); chk("ill_f3_all", {out_valid, illegal, alu_inst}, 4'b1100);
        end
        apply(2'b10, 32'hbfffefff & 32'hffff_f000 | 32'h0000_0000, 1'b1);
        chk("f3_110_noise", {out_valid, illegal, alu_inst}, 4'b1011);
        apply(2'b10, {1'bx, 1'b0, 15'bx, 3'b111, 12'bx}, 1'b1); chk("x_ignored", {out_valid, illegal, alu_inst}, 4'b1010);
        apply(2'b00, 32'hxxxxxxxx, 1'b1); chk("x_ignored_add", {out_valid, illegal, alu_inst}, 4'b1000);
        apply(2'b10, 32'h00006000, 1'b1); chk("hold_load", {out_valid, illegal, alu_inst}, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            apply(2'(i), 32'h0, 1'b0); chk("hold", {out_valid, illegal, alu_inst}, 4'b0011);
        end
        apply(2'b10, 32'h00001000, 1'b1); chk("pre_reset", {out_valid, illegal, alu_inst}, 4'b1100);
        #2 rst = 1'b1; #1;
        chk("async_reset", {out_valid, illegal, alu_inst}, 4'b0000);
        @(posedge clk); #1;
        chk("reset_ignores_input", {out_valid, illegal, alu_inst}, 4'b0000);
        rst = 1'b0;
        apply(2'b01, 32'h0, 1'b1); chk("post_reset", {out_valid, illegal, alu_inst}, 4'b1001);
        for (int i = 0; i < 400; i++) begin
            ALU_OP = 2'($urandom); instruccion = $urandom; in_valid = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1; #1;
                chk("rand_async_reset", {out_valid, illegal, alu_inst}, 4'b0000);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
